// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a small sequencer feeds the single-bit fulladder
// cell one bit pair per clock, LSB first, and closes its carry loop with a flop.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ ci;
  assign co  = (a & b) | (ci & axb);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic fa_s;
  logic fa_co;
  logic accept;
  logic last_shift;

  fulladder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_shift = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded directly from state; no input-to-output path
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load on accept, shift one bit pair per SHIFT cycle
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = c_in;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
      sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
      carry_d  = fa_co;
      cnt_d    = cnt_q + 1'b1;
    end
    // Result registers capture the completed word so sum/c_out hold through DONE and IDLE
    if (last_shift) begin
      sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
      c_out_d = fa_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2: directed table,
// backpressure, asynchronous mid-operation reset and a randomised soak.

module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid8 = 1'b0, in_ready8, c_in8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       out_valid8, out_ready8 = 1'b1, c_out8, busy8;

  logic       in_valid2 = 1'b0, in_ready2, c_in2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       out_valid2, out_ready2 = 1'b1, c_out2, busy2;

  int checks = 0;
  int errors = 0;

  int  soak_acc = 0;
  int  soak_done = 0;
  logic soak_on = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .busy(busy8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .c_in(c_in2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .c_out(c_out2), .busy(busy2)
  );

  always @(posedge clk) begin
    if (soak_on) begin
      if (in_valid8 && in_ready8) soak_acc++;
      if (out_valid8 && out_ready8) soak_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 operation; hold>0 stalls out_ready for that many DONE cycles
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input logic [7:0] es, input logic ec, input int hold);
    int edges;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready8 && w < 40) begin @(negedge clk); w++; end
    chk("op8_idle_ready", 32'(in_ready8), 32'd1);
    out_ready8 = (hold > 0) ? 1'b0 : 1'b1;
    in_valid8 = 1'b1; a8 = ta; b8 = tb_; c_in8 = tc;
    @(posedge clk); #1;
    chk("op8_accept_busy", {30'd0, in_ready8, busy8}, 32'b01);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
    edges = 1;
    @(posedge clk); #1;
    while (!out_valid8 && edges < 40) begin @(posedge clk); #1; edges++; end
    chk("op8_latency", 32'(edges), 32'd8);
    chk("op8_result", {23'd0, c_out8, sum8}, {23'd0, ec, es});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid8 = (i == 1);
      a8 = 8'hFF;
      @(posedge clk); #1;
      chk("hold_valid_ready", {30'd0, out_valid8, in_ready8}, 32'b10);
      chk("hold_result", {23'd0, c_out8, sum8}, {23'd0, ec, es});
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("op8_back_idle", {30'd0, out_valid8, in_ready8}, 32'b01);
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                     input logic [1:0] es, input logic ec);
    int edges;
    @(negedge clk);
    in_valid2 = 1'b1; a2 = ta; b2 = tb_; c_in2 = tc;
    @(posedge clk); #1;
    chk("op2_accept_busy", {30'd0, in_ready2, busy2}, 32'b01);
    @(negedge clk);
    in_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); c_in2 = 1'($urandom);
    edges = 1;
    @(posedge clk); #1;
    while (!out_valid2 && edges < 40) begin @(posedge clk); #1; edges++; end
    chk("op2_latency", 32'(edges), 32'd2);
    chk("op2_result", {29'd0, c_out2, sum2}, {29'd0, ec, es});
    @(posedge clk); #1;
    chk("op2_back_idle", {30'd0, out_valid2, in_ready2}, 32'b01);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref9;
    logic [1:0] qa, qb;
    logic       qc;
    logic [2:0] ref3;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    #12;
    chk("reset_ctrl8", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
    chk("reset_result8", {23'd0, c_out8, sum8}, 32'd0);
    chk("reset_ctrl2", {29'd0, in_ready2, out_valid2, busy2}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5);

    for (int i = 0; i < 7; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, 0);

    // Asynchronous reset between edges, three shifts into an operation
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c_in8 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
    chk("midreset_result", {23'd0, c_out8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    soak_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op8(ra, rb, rc, ref9[7:0], ref9[8], 0);
    end
    @(negedge clk);
    soak_on = 1'b0;
    chk("soak_accepts", 32'(soak_acc), 32'd1000);
    chk("soak_one_pulse_each", 32'(soak_done), 32'(soak_acc));

    op2(2'b11, 2'b01, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      qa = 2'($urandom); qb = 2'($urandom); qc = 1'($urandom);
      ref3 = {1'b0, qa} + {1'b0, qb} + {2'd0, qc};
      op2(qa, qb, qc, ref3[1:0], ref3[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
